// File: rtl/trg_sci_frame_reader.sv
// Trigger science-data frame reader: drains the FIFO, realigns on EB 90 headers,
// checks the payload CRC-16 and forwards flagged bytes through a 2-entry output buffer.
module trg_sci_frame_reader #(
    parameter int          FRAME_LEN = 20,
    parameter logic [15:0] HDR_WORD  = 16'hEB90,
    parameter logic [15:0] CRC_POLY  = 16'h1021,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enb_in,
    input  logic [7:0]  fifo_data_in,
    input  logic        fifo_empty_in,
    output logic        fifo_rd_out,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_sof,
    output logic        dout_eof,
    output logic        frame_crc_ok,
    output logic [15:0] frame_cnt,
    output logic [15:0] crc_err_cnt,
    output logic [15:0] hdr_err_cnt,
    output logic        busy_out
);

    localparam int DATA_W = 8;
    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0]  LAST_BODY = IDX_W'(FRAME_LEN - 3);
    localparam logic [DATA_W-1:0] HDR_HI    = HDR_WORD[15:8];
    localparam logic [DATA_W-1:0] HDR_LO    = HDR_WORD[7:0];

    typedef enum logic [2:0] {IDLE, HUNT, HDR1, BODY, CRCH, CRCL} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eof;
        logic              ok;
    } entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [DATA_W-1:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        return r;
    endfunction

    state_t             state, state_nxt;
    logic               vld_p1;
    logic [DATA_W-1:0]  data_p1;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [15:0]        crc, crc_nxt, crc_h, crc_h_nxt;
    logic               armed, armed_nxt;
    logic               hdr_inc;
    logic [1:0]         npush;
    entry_t             e0, e1;

    entry_t             buf_mem [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         count;
    entry_t             head;
    logic               pop, held, inframe;
    logic [2:0]         slots;

    assign data_p1 = fifo_data_in;
    assign held    = (state == HDR1);
    assign head    = buf_mem[rd_ptr];
    assign pop     = dout_valid & dout_ready;

    // Read side: the held EB and any byte in flight both claim a buffer slot,
    // and the last CRC byte in flight stops reading until the frame closes.
    always_comb begin
        case (state)
            IDLE, HUNT: inframe = enb_in;
            CRCL:       inframe = ~vld_p1;
            default:    inframe = 1'b1;
        endcase
    end

    assign slots       = 3'(count) - 3'(pop) + 3'(held) + 3'(vld_p1);
    assign fifo_rd_out = rst_in & inframe & ~fifo_empty_in & (slots < 3'd2);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        crc_nxt   = crc;
        crc_h_nxt = crc_h;
        armed_nxt = armed;
        hdr_inc   = 1'b0;
        npush     = 2'd0;
        e0        = '{data: data_p1, sof: 1'b0, eof: 1'b0, ok: 1'b0};
        e1        = '{data: data_p1, sof: 1'b0, eof: 1'b0, ok: 1'b0};
        case (state)
            IDLE: begin
                if (fifo_rd_out) begin
                    state_nxt = HUNT;
                    armed_nxt = 1'b1;
                end
            end
            HUNT: begin
                if (vld_p1) begin
                    if (data_p1 == HDR_HI) begin
                        state_nxt = HDR1;
                    end else if (armed) begin
                        hdr_inc   = 1'b1;
                        armed_nxt = 1'b0;
                    end
                end
            end
            HDR1: begin
                if (vld_p1) begin
                    if (data_p1 == HDR_LO) begin
                        npush     = 2'd2;
                        e0.data   = HDR_HI;
                        e0.sof    = 1'b1;
                        crc_nxt   = CRC_INIT;
                        idx_nxt   = IDX_W'(2);
                        state_nxt = BODY;
                    end else if (data_p1 != HDR_HI) begin
                        hdr_inc   = 1'b1;
                        armed_nxt = 1'b0;
                        state_nxt = HUNT;
                    end
                end
            end
            BODY: begin
                if (vld_p1) begin
                    npush   = 2'd1;
                    crc_nxt = crc_byte(crc, data_p1);
                    idx_nxt = idx + IDX_W'(1);
                    if (idx == LAST_BODY)
                        state_nxt = CRCH;
                end
            end
            CRCH: begin
                if (vld_p1) begin
                    npush     = 2'd1;
                    crc_h_nxt = {crc[15:8] ^ crc[15:8], data_p1} | {data_p1, 8'h00} & 16'hFF00;
                    state_nxt = CRCL;
                end
            end
            CRCL: begin
                if (vld_p1) begin
                    npush     = 2'd1;
                    e0.eof    = 1'b1;
                    e0.ok     = ({crc_h[15:8], data_p1} == crc);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: captured byte lands in the buffer; CRC state has no reset.
    always_ff @(posedge clk_in) begin
        if (npush != 2'd0)
            buf_mem[wr_ptr] <= e0;
        if (npush == 2'd2)
            buf_mem[~wr_ptr] <= e1;
        crc   <= crc_nxt;
        crc_h <= crc_h_nxt;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            vld_p1      <= 1'b0;
            idx         <= '0;
            armed       <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            frame_cnt   <= 16'd0;
            crc_err_cnt <= 16'd0;
            hdr_err_cnt <= 16'd0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= fifo_rd_out;
            idx    <= idx_nxt;
            armed  <= armed_nxt;
            wr_ptr <= wr_ptr ^ npush[0];
            rd_ptr <= rd_ptr ^ pop;
            count  <= count - 2'(pop) + npush;
            if (hdr_inc)
                hdr_err_cnt <= sat_inc(hdr_err_cnt);
            if (pop && head.eof) begin
                frame_cnt <= sat_inc(frame_cnt);
                if (!head.ok)
                    crc_err_cnt <= sat_inc(crc_err_cnt);
            end
        end
    end

    assign dout_valid   = (count != 2'd0);
    assign dout         = dout_valid ? head.data : '0;
    assign dout_sof     = dout_valid & head.sof;
    assign dout_eof     = dout_valid & head.eof;
    assign frame_crc_ok = dout_valid & head.eof & head.ok;
    assign busy_out     = (state != IDLE);

endmodule
